// File: rtl/axis_cam_hashed_if.sv
// axis_cam_hashed_if: one AXI-Stream channel of the hashed CAM.
// The same interface type carries both the command stream (slave side)
// and the response stream (master side).
interface axis_cam_hashed_if #(
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int KEY_WIDTH_BYTES  = 6,
    parameter int TID_WIDTH        = 8
) ();
    localparam int TDATA_W = (DATA_WIDTH_BYTES + KEY_WIDTH_BYTES) * 8;

    logic                 tvalid;
    logic                 tready;
    logic                 tlast;
    logic [TDATA_W-1:0]   tdata;   // {data, key}
    logic [2:0]           tuser;   // opcode (command) or status (response)
    logic [TID_WIDTH-1:0] tid;

    modport master (output tvalid, tlast, tdata, tuser, tid, input tready);
    modport slave  (input tvalid, tlast, tdata, tuser, tid, output tready);
endinterface

// File: rtl/axis_cam_hashed.sv
// axis_cam_hashed: hashed, bucketed CAM behind a pair of AXI-Stream channels.
// One command beat in (lookup/insert/delete/flush), one status beat out.
// The key selects a bucket through an XOR-fold hash; the WAYS entries of
// that bucket are compared in parallel in a single CMP cycle.
// Optional entry aging: define AXIS_CAM_HASHED_AGING_EN.
module axis_cam_hashed #(
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int KEY_WIDTH_BYTES  = 6,
    parameter int NUM_BUCKETS      = 8,
    parameter int WAYS             = 4,
    parameter int TID_WIDTH        = 8,
    parameter int AGE_PERIOD       = 1024
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    axis_cam_hashed_if.slave                       s_axis,
    axis_cam_hashed_if.master                      m_axis,
    output logic [$clog2(NUM_BUCKETS*WAYS+1)-1:0]  o_occupancy
);
    localparam int DW    = DATA_WIDTH_BYTES * 8;
    localparam int KW    = KEY_WIDTH_BYTES * 8;
    localparam int BKT_W = $clog2(NUM_BUCKETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int OCC_W = $clog2(NUM_BUCKETS*WAYS+1);

    localparam logic [2:0] OP_LOOKUP = 3'd0;
    localparam logic [2:0] OP_INSERT = 3'd1;
    localparam logic [2:0] OP_DELETE = 3'd2;
    localparam logic [2:0] OP_FLUSH  = 3'd3;

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_MISS    = 3'd1;
    localparam logic [2:0] ST_FULL    = 3'd2;
    localparam logic [2:0] ST_UPDATED = 3'd3;
    localparam logic [2:0] ST_BAD_OP  = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_e;

    // Elaboration-time sanity checks on the configuration.
    if ((NUM_BUCKETS < 2) || ((NUM_BUCKETS & (NUM_BUCKETS - 1)) != 0)) begin : g_bad_buckets
        $error("NUM_BUCKETS must be a power of two >= 2");
    end
    if ((WAYS < 1) || (WAYS > 8)) begin : g_bad_ways
        $error("WAYS must be in 1..8");
    end
    if (AGE_PERIOD < 1) begin : g_bad_age
        $error("AGE_PERIOD must be >= 1");
    end

    state_e               state_q, state_d;
    logic [KW-1:0]        cmd_key_q;
    logic [DW-1:0]        cmd_data_q;
    logic [2:0]           cmd_op_q;
    logic [TID_WIDTH-1:0] cmd_tid_q;
    logic                 cmd_tlast_q;
    logic [2:0]           resp_status_q, status_d;
    logic [DW-1:0]        resp_data_q, rdata_d;
    logic [OCC_W-1:0]     occ_q, occ_d;

    logic          tbl_valid_q [NUM_BUCKETS][WAYS];
    logic [KW-1:0] tbl_key_q   [NUM_BUCKETS][WAYS];
    logic [DW-1:0] tbl_data_q  [NUM_BUCKETS][WAYS];

    logic [BKT_W-1:0] bucket;
    logic             hit, free;
    logic [WAY_W-1:0] hit_way, free_way, wr_way;
    logic             cmd_accept, wr_en, del_en, flush_en, occ_inc, occ_dec;

    logic [NUM_BUCKETS-1:0][WAYS-1:0] expire;
    logic [OCC_W-1:0]                 expire_cnt;

    assign s_axis.tready = (state_q == S_IDLE) && !i_rst;
    assign m_axis.tvalid = (state_q == S_RESP) && !i_rst;
    assign m_axis.tdata  = {resp_data_q, cmd_key_q};
    assign m_axis.tuser  = resp_status_q;
    assign m_axis.tid    = cmd_tid_q;
    assign m_axis.tlast  = cmd_tlast_q;
    assign o_occupancy   = occ_q;

    assign cmd_accept = s_axis.tvalid && s_axis.tready;

    // Bucket index: bit i of the key folds into bucket bit (i mod BKT_W),
    // which is the XOR of all BKT_W-wide slices with the top one zero-padded.
    always_comb begin
        bucket = '0;
        for (int i = 0; i < KW; i++) begin
            bucket[i % BKT_W] = bucket[i % BKT_W] ^ cmd_key_q[i];
        end
    end

    // Parallel compare over the selected bucket; descending scan leaves the
    // lowest matching / lowest free way selected.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        free     = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (tbl_valid_q[bucket][w] && (tbl_key_q[bucket][w] == cmd_key_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!tbl_valid_q[bucket][w]) begin
                free     = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    // FSM next state plus the CMP-cycle decision: status, reply data, table edits.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        status_d = ST_OK;
        rdata_d  = cmd_data_q;
        wr_en    = 1'b0;
        wr_way   = hit_way;
        del_en   = 1'b0;
        flush_en = 1'b0;
        occ_inc  = 1'b0;
        occ_dec  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_accept) state_d = S_CMP;
            end
            S_CMP: begin
                state_d = S_RESP;
                case (cmd_op_q)
                    OP_LOOKUP: begin
                        if (hit) begin
                            rdata_d = tbl_data_q[bucket][hit_way];
                        end else begin
                            status_d = ST_MISS;
                            rdata_d  = '0;
                        end
                    end
                    OP_INSERT: begin
                        if (hit) begin
                            wr_en    = 1'b1;
                            status_d = ST_UPDATED;
                        end else if (free) begin
                            wr_en   = 1'b1;
                            wr_way  = free_way;
                            occ_inc = 1'b1;
                        end else begin
                            status_d = ST_FULL;
                        end
                    end
                    OP_DELETE: begin
                        if (hit) begin
                            del_en  = 1'b1;
                            occ_dec = 1'b1;
                        end else begin
                            status_d = ST_MISS;
                            rdata_d  = '0;
                        end
                    end
                    OP_FLUSH: flush_en = 1'b1;
                    default:  status_d = ST_BAD_OP;
                endcase
            end
            S_RESP: begin
                if (m_axis.tready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Occupancy next value: one insert or delete per command, minus aged-out entries.
    always_comb begin
        occ_d = occ_q + OCC_W'(occ_inc) - OCC_W'(occ_dec) - expire_cnt;
        if (flush_en) occ_d = '0;
    end

    // State register and occupancy counter.
    // NOTE: sequential state is written with <= so all registers update
    // together from values sampled before the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
        end
    end

    // Command capture and response hold registers (datapath, no reset needed:
    // they are only observed while a response is valid).
    always_ff @(posedge i_clk) begin
        if (cmd_accept) begin
            cmd_key_q   <= s_axis.tdata[KW-1:0];
            cmd_data_q  <= s_axis.tdata[DW+KW-1:KW];
            cmd_op_q    <= s_axis.tuser;
            cmd_tid_q   <= s_axis.tid;
            cmd_tlast_q <= s_axis.tlast;
        end
        if (state_q == S_CMP) begin
            resp_status_q <= status_d;
            resp_data_q   <= rdata_d;
        end
    end

    // Entry valid bits: reset/flush clear everything, then aging, then the command edit.
    always_ff @(posedge i_clk) begin
        if (i_rst || flush_en) begin
            for (int b = 0; b < NUM_BUCKETS; b++) begin
                for (int w = 0; w < WAYS; w++) tbl_valid_q[b][w] <= 1'b0;
            end
        end else begin
            for (int b = 0; b < NUM_BUCKETS; b++) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (expire[b][w]) tbl_valid_q[b][w] <= 1'b0;
                end
            end
            if (wr_en)  tbl_valid_q[bucket][wr_way]  <= 1'b1;
            if (del_en) tbl_valid_q[bucket][hit_way] <= 1'b0;
        end
    end

    // Entry key/data storage.
    // NOTE: the key/data array is not reset; the valid bits alone define
    // which contents are meaningful.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            tbl_key_q[bucket][wr_way]  <= cmd_key_q;
            tbl_data_q[bucket][wr_way] <= cmd_data_q;
        end
    end

`ifdef AXIS_CAM_HASHED_AGING_EN
    localparam int PRESC_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

    logic [PRESC_W-1:0] presc_q;
    logic [1:0]         age_q [NUM_BUCKETS][WAYS];
    logic               tick, acc_en;
    logic [WAY_W-1:0]   acc_way;

    assign tick = (presc_q == PRESC_W'(AGE_PERIOD - 1));

    // The entry touched by the current CMP (hit, update or fresh insert) is
    // refreshed to age 0 and shielded from a coincident tick.
    always_comb begin
        acc_en  = 1'b0;
        acc_way = hit ? hit_way : free_way;
        if (state_q == S_CMP) begin
            case (cmd_op_q)
                OP_LOOKUP, OP_DELETE: acc_en = hit;
                OP_INSERT:            acc_en = hit || free;
                default:              acc_en = 1'b0;
            endcase
        end
    end

    // On a tick, valid entries already at age 3 expire.
    always_comb begin
        expire     = '0;
        expire_cnt = '0;
        for (int b = 0; b < NUM_BUCKETS; b++) begin
            for (int w = 0; w < WAYS; w++) begin
                if (tick && tbl_valid_q[b][w] && (age_q[b][w] == 2'd3) &&
                    !(acc_en && (BKT_W'(b) == bucket) && (WAY_W'(w) == acc_way))) begin
                    expire[b][w] = 1'b1;
                    expire_cnt   = expire_cnt + OCC_W'(1);
                end
            end
        end
    end

    // Prescaler and per-entry ages.
    always_ff @(posedge i_clk) begin
        if (i_rst || flush_en) begin
            presc_q <= '0;
            for (int b = 0; b < NUM_BUCKETS; b++) begin
                for (int w = 0; w < WAYS; w++) age_q[b][w] <= 2'd0;
            end
        end else begin
            presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
            if (tick) begin
                for (int b = 0; b < NUM_BUCKETS; b++) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (tbl_valid_q[b][w] && (age_q[b][w] != 2'd3)) age_q[b][w] <= age_q[b][w] + 2'd1;
                    end
                end
            end
            if (acc_en) age_q[bucket][acc_way] <= 2'd0;
        end
    end
`else
    assign expire     = '0;
    assign expire_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_cam_hashed.sv
// tb_axis_cam_hashed: directed scenarios plus randomized traffic against a
// key-indexed reference model; expected replies go into a scoreboard queue
// and an independent monitor compares every response beat.
module tb_axis_cam_hashed;
    localparam int DATA_WIDTH_BYTES = 1;
    localparam int KEY_WIDTH_BYTES  = 6;
    localparam int NUM_BUCKETS      = 8;
    localparam int WAYS             = 4;
    localparam int TID_WIDTH        = 8;
    localparam int DW    = DATA_WIDTH_BYTES * 8;
    localparam int KW    = KEY_WIDTH_BYTES * 8;
    localparam int OCC_W = $clog2(NUM_BUCKETS*WAYS+1);

    localparam logic [2:0] OP_LOOKUP = 3'd0;
    localparam logic [2:0] OP_INSERT = 3'd1;
    localparam logic [2:0] OP_DELETE = 3'd2;
    localparam logic [2:0] OP_FLUSH  = 3'd3;

    typedef struct {
        logic [2:0]           status;
        logic [DW+KW-1:0]     tdata;
        logic [TID_WIDTH-1:0] tid;
        logic                 tlast;
        int                   occ;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [OCC_W-1:0] occupancy;
    int               rdy_mode;     // 0 random, 1 always ready, 2 stalled
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [TID_WIDTH-1:0] next_tid = '0;
    exp_t             sbq [$];

    // Reference model: key -> data, plus per-bucket fill counts.
    logic [DW-1:0]    mdl [logic [KW-1:0]];
    int               bkt_cnt [NUM_BUCKETS];
    int               mdl_occ;

    always #5 clk = ~clk;

    axis_cam_hashed_if #(.DATA_WIDTH_BYTES(DATA_WIDTH_BYTES), .KEY_WIDTH_BYTES(KEY_WIDTH_BYTES),
                         .TID_WIDTH(TID_WIDTH)) s_if ();
    axis_cam_hashed_if #(.DATA_WIDTH_BYTES(DATA_WIDTH_BYTES), .KEY_WIDTH_BYTES(KEY_WIDTH_BYTES),
                         .TID_WIDTH(TID_WIDTH)) m_if ();

    axis_cam_hashed #(
        .DATA_WIDTH_BYTES(DATA_WIDTH_BYTES),
        .KEY_WIDTH_BYTES (KEY_WIDTH_BYTES),
        .NUM_BUCKETS     (NUM_BUCKETS),
        .WAYS            (WAYS),
        .TID_WIDTH       (TID_WIDTH),
        .AGE_PERIOD      (1024)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .o_occupancy (occupancy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bucket = XOR of the base-NUM_BUCKETS digits of the key.
    function automatic int hash_of(input logic [KW-1:0] k);
        int            h = 0;
        logic [KW-1:0] t = k;
        while (t != 0) begin
            h ^= int'(t % KW'(NUM_BUCKETS));
            t = t / KW'(NUM_BUCKETS);
        end
        return h;
    endfunction

    function automatic void model_reset();
        mdl.delete();
        for (int b = 0; b < NUM_BUCKETS; b++) bkt_cnt[b] = 0;
        mdl_occ = 0;
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [KW-1:0] key, input logic [DW-1:0] data);
        exp_t e;
        int   h = hash_of(key);
        e.status = 3'd0;
        e.tdata  = {data, key};
        e.tid    = '0;
        e.tlast  = 1'b0;
        case (op)
            OP_LOOKUP: begin
                if (mdl.exists(key)) e.tdata = {mdl[key], key};
                else begin e.status = 3'd1; e.tdata = {{DW{1'b0}}, key}; end
            end
            OP_INSERT: begin
                if (mdl.exists(key)) begin mdl[key] = data; e.status = 3'd3; end
                else if (bkt_cnt[h] == WAYS) e.status = 3'd2;
                else begin mdl[key] = data; bkt_cnt[h]++; mdl_occ++; end
            end
            OP_DELETE: begin
                if (mdl.exists(key)) begin mdl.delete(key); bkt_cnt[h]--; mdl_occ--; end
                else begin e.status = 3'd1; e.tdata = {{DW{1'b0}}, key}; end
            end
            OP_FLUSH: model_reset();
            default:  e.status = 3'd7;
        endcase
        e.occ = mdl_occ;
        return e;
    endfunction

    // Issue one command; entered and left at posedge+1. With abort set the
    // command is expected to be killed by reset, so nothing is scoreboarded.
    task automatic send(input logic [2:0] op, input logic [KW-1:0] key, input logic [DW-1:0] data,
                        input bit abort);
        exp_t e;
        bit   ok = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tuser  = op;
        s_if.tdata  = {data, key};
        s_if.tid    = next_tid;
        s_if.tlast  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (s_if.tready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            check("accept_timeout", 64'(s_if.tready), 64'd1);
            s_if.tvalid = 1'b0;
            return;
        end
        if (!abort) begin
            e       = model(op, key, data);
            e.tid   = next_tid;
            e.tlast = s_if.tlast;
            sbq.push_back(e);
        end
        next_tid++;
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) check("drain_timeout", 64'(sbq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Response-side ready generator.
    initial begin : ready_gen
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_if.tready = ($urandom_range(0, 3) != 0);
                1:       m_if.tready = 1'b1;
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    // Monitor: latency, stability under backpressure, and scoreboard compare.
    initial begin : monitor
        exp_t             e;
        logic [DW+KW-1:0] snap_data;
        logic [11:0]      snap_ctl;
        bit               in_resp;
        int               cyc;
        int               acc_cyc;
        in_resp = 1'b0;
        cyc     = 0;
        acc_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_resp = 1'b0;
                continue;
            end
            if (s_if.tvalid && s_if.tready) acc_cyc = cyc;
            if (m_if.tvalid) begin
                if (!in_resp) begin
                    check("latency", 64'(cyc), 64'(acc_cyc + 2));
                    in_resp   = 1'b1;
                    snap_data = m_if.tdata;
                    snap_ctl  = {m_if.tuser, m_if.tid, m_if.tlast};
                end else begin
                    check("hold_tdata", 64'(m_if.tdata), 64'(snap_data));
                    check("hold_ctl", 64'({m_if.tuser, m_if.tid, m_if.tlast}), 64'(snap_ctl));
                    check("s_tready_in_resp", 64'(s_if.tready), 64'd0);
                end
                if (m_if.tready) begin
                    in_resp = 1'b0;
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_resp: got status %0d tid 0x%0h, expected no response", m_if.tuser, m_if.tid);
                    end else begin
                        e = sbq.pop_front();
                        check("status", 64'(m_if.tuser), 64'(e.status));
                        check("tdata", 64'(m_if.tdata), 64'(e.tdata));
                        check("tid", 64'(m_if.tid), 64'(e.tid));
                        check("tlast", 64'(m_if.tlast), 64'(e.tlast));
                        check("occupancy", 64'(occupancy), 64'(e.occ));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [KW-1:0] b0_keys [5];
        logic [KW-1:0] pool [24];
        logic [2:0]    op;
        int            r;

        rst         = 1'b1;
        rdy_mode    = 1;
        s_if.tvalid = 1'b0;
        s_if.tuser  = '0;
        s_if.tdata  = '0;
        s_if.tid    = '0;
        s_if.tlast  = 1'b0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Insert then lookup one key.
        send(OP_INSERT, 48'h0000_0000_0001, 8'hAA, 1'b0);
        send(OP_LOOKUP, 48'h0000_0000_0001, 8'h00, 1'b0);

        // Five keys folding into bucket 0: the fifth finds the bucket full.
        b0_keys[0] = 48'h00; b0_keys[1] = 48'h09; b0_keys[2] = 48'h12;
        b0_keys[3] = 48'h1B; b0_keys[4] = 48'h24;
        for (int i = 0; i < 5; i++) send(OP_INSERT, b0_keys[i], 8'(8'h10 + i), 1'b0);

        // Update, lookup, delete, delete-miss.
        send(OP_INSERT, 48'h09, 8'h55, 1'b0);
        send(OP_LOOKUP, 48'h09, 8'h00, 1'b0);
        send(OP_DELETE, 48'h09, 8'h00, 1'b0);
        send(OP_DELETE, 48'h09, 8'h00, 1'b0);

        // Backpressure: hold the response for 10 cycles.
        wait_idle();
        rdy_mode = 2;
        send(OP_LOOKUP, 48'h12, 8'h00, 1'b0);
        for (int i = 0; i < 20 && !m_if.tvalid; i++) @(negedge clk);
        check("stall_valid_seen", 64'(m_if.tvalid), 64'd1);
        repeat (10) @(posedge clk);
        rdy_mode = 1;
        wait_idle();

        // Illegal opcode, then flush with six entries present.
        send(3'd5, 48'h12, 8'h77, 1'b0);
        send(OP_INSERT, 48'h100, 8'h01, 1'b0);
        send(OP_INSERT, 48'h200, 8'h02, 1'b0);
        wait_idle();
        check("occ_before_flush", 64'(occupancy), 64'd6);
        send(OP_FLUSH, 48'hDEAD_BEEF_0000, 8'h3C, 1'b0);
        send(OP_LOOKUP, 48'h1, 8'h00, 1'b0);
        send(OP_LOOKUP, 48'h12, 8'h00, 1'b0);
        send(OP_LOOKUP, 48'h100, 8'h00, 1'b0);

        // Reset asserted during CMP drops the command.
        send(OP_INSERT, 48'h77, 8'h99, 1'b0);
        wait_idle();
        send(OP_LOOKUP, 48'h77, 8'h00, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (10) @(posedge clk);
        #1;
        check("occ_after_rst", 64'(occupancy), 64'd0);
        send(OP_LOOKUP, 48'h77, 8'h00, 1'b0);

        // Randomized traffic over a small key pool (first 8 keys share bucket 0).
        for (int i = 0; i < 24; i++) begin
            if (i < 8) pool[i] = KW'(i * 9);
            else       pool[i] = KW'({$urandom(), $urandom()});
        end
        wait_idle();
        rdy_mode = 0;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if      (r < 35) op = OP_LOOKUP;
            else if (r < 65) op = OP_INSERT;
            else if (r < 90) op = OP_DELETE;
            else if (r < 93) op = OP_FLUSH;
            else             op = 3'($urandom_range(4, 7));
            send(op, pool[$urandom_range(0, 23)], 8'($urandom()), 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rdy_mode = 1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
